// File: rtl/wide_add_seq.sv
// Multi-word adder sequencer: runs WORDS 16-bit additions through one shared
// registered adder, LS word first, rippling the carry through a register.
module wide_add_seq #(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*WORDS-1:0]   a_in,
    input  logic [16*WORDS-1:0]   b_in,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   sum_out,
    output logic                  cout,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(ADD_LAT + 1);
    localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_C = CW'(ADD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [16*WORDS-1:0]   r_a;
    logic [16*WORDS-1:0]   r_b;
    logic [16*WORDS-1:0]   r_res;
    logic [16*WORDS-1:0]   r_sum_out;
    logic                  r_carry;
    logic                  r_cout;
    logic [KW-1:0]         r_k;
    logic [CW-1:0]         r_cnt;
    logic [15:0]           r_add_a;
    logic [15:0]           r_add_b;
    logic                  r_add_cin;

    logic                  w_busy;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_last_cnt;
    logic                  w_last_word;
    logic [KW-1:0]         w_k_nxt;
    logic [16*WORDS-1:0]   w_res_nxt;

    // FIN also accepts so back-to-back requests lose no cycle.
    assign w_accept    = start && (r_state != S_RUN);
    assign w_last_cnt  = (r_cnt == LAST_C);
    assign w_last_word = (r_k == LAST_K);
    assign w_k_nxt     = r_k + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_cnt && w_last_word) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_FIN:   w_done = 1'b1;
            default: ;
        endcase
    end

    // Result including the word being captured, so the final load is atomic.
    always_comb begin
        w_res_nxt = r_res;
        w_res_nxt[{r_k, 4'h0} +: 16] = add_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_sum_out <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end else if (w_accept) begin
            r_a       <= a_in;
            r_b       <= b_in;
            r_carry   <= cin;
            r_k       <= '0;
            r_cnt     <= '0;
            r_add_a   <= a_in[15:0];
            r_add_b   <= b_in[15:0];
            r_add_cin <= cin;
        end else if (r_state == S_RUN) begin
            if (w_last_cnt) begin
                r_res   <= w_res_nxt;
                r_carry <= add_cout;
                r_cnt   <= '0;
                if (w_last_word) begin
                    r_sum_out <= w_res_nxt;
                    r_cout    <= add_cout;
                    r_add_a   <= '0;
                    r_add_b   <= '0;
                    r_add_cin <= 1'b0;
                end else begin
                    r_k       <= w_k_nxt;
                    r_add_a   <= r_a[{w_k_nxt, 4'h0} +: 16];
                    r_add_b   <= r_b[{w_k_nxt, 4'h0} +: 16];
                    r_add_cin <= add_cout;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_cin <= 1'b0;
        end
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign sum_out = r_sum_out;
    assign cout    = r_cout;
    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign add_cin = r_add_cin;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: one instance with a 1-cycle adder, one with a
// 3-cycle adder, selected by 'sel'; vector table plus reset/ignore sequences.
module tb_wide_add_seq;
    localparam int W  = 4;
    localparam int WW = 16 * W;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0, sel = 1'b0;
    logic [WW-1:0] a_in = '0, b_in = '0;
    logic start1, start3;
    assign start1 = start && !sel;
    assign start3 = start && sel;

    logic busy1, done1, cout1, add_cin1, add_cout1;
    logic busy3, done3, cout3, add_cin3, add_cout3;
    logic [WW-1:0] sum1, sum3;
    logic [15:0] add_a1, add_b1, add_sum1, add_a3, add_b3, add_sum3;

    wide_add_seq #(.WORDS(W), .ADD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1));

    wide_add_seq #(.WORDS(W), .ADD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy3), .done(done3), .sum_out(sum3), .cout(cout3),
        .add_a(add_a3), .add_b(add_b3), .add_cin(add_cin3),
        .add_sum(add_sum3), .add_cout(add_cout3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered adders of latency 1 and 3.
    logic [16:0] p1;
    logic [16:0] p3 [3];
    always @(posedge clk) begin
        p1    <= {1'b0, add_a1} + {1'b0, add_b1} + 17'(add_cin1);
        p3[0] <= {1'b0, add_a3} + {1'b0, add_b3} + 17'(add_cin3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {add_cout1, add_sum1} = p1;
    assign {add_cout3, add_sum3} = p3[2];

    logic m_busy, m_done, m_cout, m_add_cin;
    logic [WW-1:0] m_sum;
    logic [15:0] m_add_a, m_add_b;
    assign m_busy    = sel ? busy3    : busy1;
    assign m_done    = sel ? done3    : done1;
    assign m_cout    = sel ? cout3    : cout1;
    assign m_sum     = sel ? sum3     : sum1;
    assign m_add_a   = sel ? add_a3   : add_a1;
    assign m_add_b   = sel ? add_b3   : add_b1;
    assign m_add_cin = sel ? add_cin3 : add_cin1;

    typedef struct {
        logic [WW-1:0] s;
        logic          c;
        int            acc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [WW-1:0] a, b;
        logic          ci;
        logic [WW-1:0] s;
        logic          c;
        bit            noise;
    } vec_t;
    vec_t vt[8];

    int n_cmp = 0, n_fail = 0;
    logic [WW-1:0] held_s;
    logic          held_c;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic run_op(input logic [WW-1:0] a, b, input logic ci,
                          input logic [WW-1:0] es, input logic ec, input bit noise);
        int lat, n, g, k, dly;
        logic [16:0] t17;
        logic [W:0]  car;
        sb_t e;
        lat = sel ? 3 : 1;
        n   = W * (lat + 1);
        g   = 0;
        while (m_busy && g < 100) begin @(negedge clk); g++; end
        chk("idle_before_start", 128'(m_busy), 128'(0));
        car[0] = ci;
        for (int i = 0; i < W; i++) begin
            t17 = {1'b0, a[16*i +: 16]} + {1'b0, b[16*i +: 16]} + 17'(car[i]);
            car[i+1] = t17[16];
        end
        a_in = a; b_in = b; cin = ci; start = 1'b1;
        sb.push_back('{es, ec, cyc + 1});
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            k = (t - 1) / (lat + 1);
            chk("operands", 128'({m_add_a, m_add_b, m_add_cin}),
                128'({a[16*k +: 16], b[16*k +: 16], car[k]}));
            chk("busy_held", 128'({m_busy, m_done, m_sum, m_cout}),
                128'({2'b10, held_s, held_c}));
            if (t == 1) begin start = 1'b0; a_in = ~a; b_in = ~b; cin = ~ci; end
            if (noise && t == 3) begin
                start = 1'b1; a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
            end
            if (noise && t == 4) start = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 128'({m_done, m_busy}), 128'(2'b10));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'(1), 128'(0));
        end else begin
            e = sb.pop_front();
            dly = cyc - e.acc + 1;
            chk("sum_out", 128'(m_sum), 128'(e.s));
            chk("cout", 128'(m_cout), 128'(e.c));
            chk("done_cycle", 128'(dly), 128'(n + 1));
            held_s = e.s; held_c = e.c;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int dcnt;
        logic [64:0] m;
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vt[1] = '{64'h9249_9249_9249_9249, 64'h739C_739C_739C_739C, 1'b0,
                  64'h05E6_05E6_05E6_05E5, 1'b1, 1'b1};
        vt[2] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 64'h0, 1'b1, 1'b0};
        vt[3] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vt[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
        for (int i = 5; i < 8; i++) begin
            vt[i].a = {$urandom, $urandom};
            vt[i].b = {$urandom, $urandom};
            vt[i].ci = 1'($urandom_range(0, 1));
            m = {1'b0, vt[i].a} + {1'b0, vt[i].b} + 65'(vt[i].ci);
            vt[i].s = m[63:0];
            vt[i].c = m[64];
            vt[i].noise = (i == 6);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state_lat1", 128'({busy1, done1, sum1, cout1, add_a1, add_b1, add_cin1}), 128'(0));
        chk("reset_state_lat3", 128'({busy3, done3, sum3, cout3, add_a3, add_b3, add_cin3}), 128'(0));
        held_s = '0; held_c = 1'b0;

        // Back-to-back table: each op starts in the previous op's done cycle.
        for (int i = 0; i < 8; i++)
            run_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].s, vt[i].c, vt[i].noise);

        // Reset during word 1 discards the op.
        @(negedge clk);
        a_in = 64'h0123_4567_89AB_CDEF; b_in = 64'hFEDC_BA98_7654_3210; cin = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_op_reset", 128'({busy1, done1, sum1, cout1, add_a1, add_b1, add_cin1}), 128'(0));
        held_s = '0; held_c = 1'b0;
        dcnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (m_done) dcnt++;
        end
        chk("no_done_after_reset", 128'(dcnt), 128'(0));
        run_op(64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0);

        // Latency-3 instance.
        @(negedge clk);
        sel = 1'b1;
        held_s = '0; held_c = 1'b0;
        run_op(64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0);
        run_op(64'h9249_9249_9249_9249, 64'h739C_739C_739C_739C, 1'b0,
               64'h05E6_05E6_05E6_05E5, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Sequencer that performs WORDS×16-bit additions by driving one shared registered 16-bit adder (the BigAdder datapath) word by word, least-significant word first, and rippling carry between words in a register. It sits between a requester (start/done handshake) and the adder instance, which it owns exclusively while busy. It holds the adder operands stable for the adder's full latency and captures each partial sum.

## Interface
Parameters:
- WORDS, 4, number of 16-bit words per operand (legal 2..8)
- ADD_LAT, 1, adder latency in clk cycles from operand drive to sum valid (legal 1..4)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- a_in  in  16*WORDS  operand A, word k = a_in[16k+15:16k]
- b_in  in  16*WORDS  operand B, same word mapping
- cin  in  1  carry into word 0
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- sum_out  out  16*WORDS  result, held until next done
- cout  out  1  carry out of top word, held with sum_out
- add_a  out  16  adder operand A
- add_b  out  16  adder operand B
- add_cin  out  1  adder carry in
- add_sum  in  16  adder sum, valid ADD_LAT cycles after operands driven
- add_cout  in  1  adder carry out, same timing as add_sum

## Operation
- States: IDLE, RUN, FIN.
- IDLE: add_a/add_b/add_cin driven 0. On start=1: latch a_in, b_in, cin into internal registers; word index k=0; wait counter=0; carry reg=cin; go RUN. Inputs a_in/b_in/cin are don't-care after the accept edge.
- RUN: add_a/add_b = latched word k, add_cin = carry reg, all held constant for ADD_LAT+1 cycles. Counter counts 0..ADD_LAT. At the edge when counter=ADD_LAT: result word k <= add_sum, carry reg <= add_cout, counter <= 0. If k=WORDS-1, go FIN; else k <= k+1, stay RUN.
- FIN (one cycle): done=1, busy=0; sum_out <= internal result, cout <= carry reg are loaded at the RUN→FIN edge, so they are valid during the done cycle. Go IDLE, or straight to RUN if start=1 this cycle (back-to-back accept, new operands latched).
- sum_out/cout update atomically only on RUN→FIN; never show partial results.
- start while busy=1: ignored, no queueing.
- Arithmetic: unsigned modulo 2^(16*WORDS), overflow reported only via cout.
- rst at any time (including mid-RUN): state IDLE, busy=0, done=0, sum_out=0, cout=0, add_a=add_b=0, add_cin=0, k=0, counter=0; in-flight operation discarded, no done pulse.

## Timing
- Start accepted at edge E0. busy=1 from cycle after E0 through cycle ending at E(WORDS*(ADD_LAT+1)).
- Word k operands driven during cycles 1+k*(ADD_LAT+1) .. (k+1)*(ADD_LAT+1) after E0; captured at edge E((k+1)*(ADD_LAT+1)).
- done=1 for exactly one cycle following edge E(WORDS*(ADD_LAT+1)); WORDS=4, ADD_LAT=1 → done in cycle 9 after accept.
- Back-to-back throughput: one operation per WORDS*(ADD_LAT+1)+1 cycles.
- All outputs registered; no combinational path from start/a_in/b_in to any output.

## Test plan
- WORDS=4, ADD_LAT=1: A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, cin=0 -> sum_out=0, cout=1, done exactly 9 cycles after accept edge, busy high 8 cycles.
- A=64'h9249_9249_9249_9249, B=64'h739C_739C_739C_739C, cin=0 -> sum_out=64'h05E6_05E6_05E6_05E5, cout=1; add_a/add_b/add_cin stable for 2 cycles per word, in order word0..word3.
- A=64'hF0F0_F0F0_F0F0_F0F0, B=64'h0F0F_0F0F_0F0F_0F0F, cin=1 -> sum_out=0, cout=1 (full carry ripple); same operands with cin=0 -> sum_out=64'hFFFF_FFFF_FFFF_FFFF, cout=0.
- Pulse start with different operands during busy -> ignored, first result unchanged; assert start in done cycle -> accepted, second done 9 cycles later, sum_out from first op held until then.
- rst for one cycle during word 1 of an op -> all outputs 0 next cycle, no done ever for that op; new start afterwards completes correctly.
- ADD_LAT=3 build with bench adder of 3-cycle latency: A=64'h1, B=64'h1 -> sum_out=64'h2, cout=0, done 17 cycles after accept, each word held 4 cycles.
